// File: rtl/adder_sweep_checker.sv
// adder_sweep_checker: hardware stimulus generator and result checker for an adder DUT
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start               begin a sweep (accepted in IDLE or DONE only)
//   stall               hold operands and issue a bubble this cycle
//   a_out/b_out/cin_out operands to the DUT
//   dut_sum/dut_cout    DUT result, expected DUT_LATENCY cycles after the operands
//   busy/done/pass      status: RUN or DRAIN / DONE / DONE with no mismatches
//   vec_count/err_count vectors compared / mismatches (saturating)
//   first_err_valid/first_err_vec  {cin,b,a} of the first mismatching vector
module adder_sweep_checker #(
    parameter int WIDTH       = 4,
    parameter int DUT_LATENCY = 0,
    parameter int MODE        = 0,
    parameter int NUM_VECTORS = 100,
    parameter int LFSR_SEED   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic               cin_out,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH+1:0] vec_count,
    output logic [2*WIDTH+1:0] err_count,
    output logic               first_err_valid,
    output logic [2*WIDTH:0]   first_err_vec
);
    localparam int VW = 2*WIDTH+1;
    localparam int CW = VW+1;
    localparam int SW = 1+VW+WIDTH+1;

    // Galois feedback masks for maximal-length LFSRs of every legal odd length
    function automatic logic [32:0] taps(input int n);
        case (n)
            3:       taps = 33'h6;
            5:       taps = 33'h14;
            7:       taps = 33'h60;
            9:       taps = 33'h110;
            11:      taps = 33'h500;
            13:      taps = 33'h100D;
            15:      taps = 33'h6000;
            17:      taps = 33'h12000;
            19:      taps = 33'h40023;
            21:      taps = 33'h140000;
            23:      taps = 33'h420000;
            25:      taps = 33'h1200000;
            27:      taps = 33'h4000013;
            29:      taps = 33'h14000000;
            31:      taps = 33'h48000000;
            33:      taps = 33'h100080000;
            default: taps = 33'h0;
        endcase
    endfunction

    localparam logic [32:0]   TAPS   = taps(VW);
    localparam logic [VW-1:0] MASK   = TAPS[VW-1:0];
    localparam logic [VW-1:0] FIRST  = MODE == 1 ? VW'(LFSR_SEED) : '0;
    localparam logic [3:0]    LAT_M1 = 4'(DUT_LATENCY == 0 ? 0 : DUT_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic [VW-1:0] ops_q, iss_q, fev_q, ops_d, slot_vec;
    logic [3:0]    drn_q;
    logic [CW-1:0] vec_q, err_q, err_d;
    logic          fev_ok_q, pass_q, busy_q, done_q;
    logic          clr, issue, last, hit, mis;
    logic [WIDTH:0] exp_w, slot_exp;
    logic [SW-1:0] slot_in, slot_out;

    assign clr   = start && (state_q == IDLE || state_q == DONE);
    assign issue = state_q == RUN && !stall;
    assign last  = MODE == 1 ? iss_q == VW'(NUM_VECTORS - 1) : &ops_q;
    assign ops_d = MODE == 1 ? (ops_q >> 1) ^ (ops_q[0] ? MASK : '0) : ops_q + 1'b1;
    assign exp_w = (WIDTH+1)'(ops_q[WIDTH-1:0]) + (WIDTH+1)'(ops_q[2*WIDTH-1:WIDTH])
                 + (WIDTH+1)'(ops_q[VW-1]);
    assign slot_in = {issue, ops_q, exp_w};

    generate
        if (DUT_LATENCY == 0) begin : g_nodly
            assign slot_out = slot_in;
        end else begin : g_dly
            logic [DUT_LATENCY*SW-1:0] dl_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst || clr) dl_q <= '0;
                else dl_q <= (DUT_LATENCY*SW)'({dl_q, slot_in});
            end
            assign slot_out = dl_q[DUT_LATENCY*SW-1 -: SW];
        end
    endgenerate

    assign hit      = slot_out[SW-1];
    assign slot_vec = slot_out[SW-2 -: VW];
    assign slot_exp = slot_out[WIDTH:0];
    assign mis      = hit && {dut_cout, dut_sum} != slot_exp;
    assign err_d    = err_q + CW'(mis && !(&err_q));

    always_comb begin
        state_d = state_q;
        if (clr) state_d = RUN;
        else if (issue && last) state_d = DUT_LATENCY == 0 ? DONE : DRAIN;
        else if (state_q == DRAIN && drn_q == 4'd0) state_d = DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ops_q    <= '0;
            iss_q    <= '0;
            drn_q    <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            fev_ok_q <= 1'b0;
            fev_q    <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d == RUN || state_d == DRAIN;
            done_q  <= state_d == DONE;
            if (clr) begin
                ops_q    <= FIRST;
                iss_q    <= '0;
                drn_q    <= LAT_M1;
                vec_q    <= '0;
                err_q    <= '0;
                fev_ok_q <= 1'b0;
                fev_q    <= '0;
                pass_q   <= 1'b0;
            end else begin
                vec_q <= vec_q + CW'(hit);
                err_q <= err_d;
                if (mis && !fev_ok_q) begin
                    fev_ok_q <= 1'b1;
                    fev_q    <= slot_vec;
                end
                if (issue) begin
                    iss_q <= iss_q + 1'b1;
                    // the counter parks on the final vector instead of wrapping
                    if (!last) ops_q <= ops_d;
                end
                if (state_q == DRAIN && drn_q != 4'd0) drn_q <= drn_q - 4'd1;
                if (state_q != DONE && state_d == DONE) pass_q <= err_d == '0;
            end
        end
    end

    assign {cin_out, b_out, a_out} = ops_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign vec_count       = vec_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_ok_q;
    assign first_err_vec   = fev_q;
endmodule

// File: tb/tb_adder_sweep_checker.sv
// tb_adder_sweep_checker: scoreboard bench for three checker configurations
module tb_adder_sweep_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] start = '0;
    logic [2:0] stall = '0;
    logic [2:0][3:0] a_w, b_w, s_w;
    logic [2:0] cin_w, co_w, busy_w, done_w, pass_w, fv_w;
    logic [2:0][9:0] vc_w, ec_w;
    logic [2:0][8:0] fe_w;
    logic [4:0] sum0, dly0, r1, r2;
    int fmode = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {int k; int vec; int err; int fev; int busy; bit fv; bit pass; bit stl;} exp_t;
    exp_t sb [$];

    always #5 clk = ~clk;

    assign sum0 = a_w[0] + b_w[0] + cin_w[0];
    always @(posedge clk) begin
        dly0 <= sum0;
        r1   <= a_w[1] + b_w[1] + cin_w[1];
        r2   <= r1;
    end
    assign {co_w[0], s_w[0]} = fmode == 1 ? {sum0[4:1], 1'b0} : fmode == 2 ? dly0 : sum0;
    assign {co_w[1], s_w[1]} = r2;
    assign {co_w[2], s_w[2]} = a_w[2] + b_w[2] + cin_w[2];

    adder_sweep_checker #(.WIDTH(4), .DUT_LATENCY(0), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .stall(stall[0]),
        .a_out(a_w[0]), .b_out(b_w[0]), .cin_out(cin_w[0]),
        .dut_sum(s_w[0]), .dut_cout(co_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .vec_count(vc_w[0]), .err_count(ec_w[0]),
        .first_err_valid(fv_w[0]), .first_err_vec(fe_w[0]));

    adder_sweep_checker #(.WIDTH(4), .DUT_LATENCY(2), .MODE(0)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .stall(stall[1]),
        .a_out(a_w[1]), .b_out(b_w[1]), .cin_out(cin_w[1]),
        .dut_sum(s_w[1]), .dut_cout(co_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .vec_count(vc_w[1]), .err_count(ec_w[1]),
        .first_err_valid(fv_w[1]), .first_err_vec(fe_w[1]));

    adder_sweep_checker #(.WIDTH(4), .DUT_LATENCY(0), .MODE(1), .NUM_VECTORS(100), .LFSR_SEED(1)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .stall(stall[2]),
        .a_out(a_w[2]), .b_out(b_w[2]), .cin_out(cin_w[2]),
        .dut_sum(s_w[2]), .dut_cout(co_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .vec_count(vc_w[2]), .err_count(ec_w[2]),
        .first_err_valid(fv_w[2]), .first_err_vec(fe_w[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_out(input int k);
        return {a_w[k], b_w[k], cin_w[k], busy_w[k], done_w[k], pass_w[k],
                vc_w[k], ec_w[k], fv_w[k], fe_w[k]};
    endfunction

    task automatic run(input exp_t e, input int abort_at);
        int v = 0;
        int sc = 0;
        int busy_n = 0;
        int cyc = 0;
        int total;
        bit trig = 0;
        logic [8:0] ov;
        bit seen [int];
        exp_t r;
        total = e.k == 2 ? 100 : 512;
        sb.push_back(e);
        @(negedge clk) start[e.k] = 1'b1;
        @(negedge clk) start[e.k] = 1'b0;
        while (!done_w[e.k] && cyc < 2000) begin
            cyc++;
            ov = {cin_w[e.k], b_w[e.k], a_w[e.k]};
            if (busy_w[e.k]) busy_n++;
            if (busy_w[e.k] && v < total) begin
                if (v == abort_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check("outputs_in_reset", all_out(e.k), 64'd0);
                    @(negedge clk) rst = 1'b0;
                    void'(sb.pop_back());
                    return;
                end
                if (e.stl && (v == 10 || v == 300) && !trig) begin
                    sc = 3;
                    trig = 1;
                end
                stall[e.k] = sc > 0;
                if (e.k == 2) begin
                    check("lfsr_nonzero", ov != 9'd0, 1);
                    check("lfsr_repeat", seen.exists(int'(ov)), 0);
                    seen[int'(ov)] = 1;
                end else check("operands", ov, v);
                if (sc > 0) sc--;
                else begin
                    v++;
                    trig = 0;
                end
            end else stall[e.k] = 1'b0;
            @(negedge clk);
        end
        stall[e.k] = 1'b0;
        check("done_reached", done_w[e.k], 1);
        r = sb.pop_front();
        check("vec_count", vc_w[r.k], r.vec);
        if (r.err < 0) check("err_nonzero", ec_w[r.k] != 10'd0, 1);
        else check("err_count", ec_w[r.k], r.err);
        check("first_err_valid", fv_w[r.k], r.fv);
        if (r.fev >= 0) check("first_err_vec", fe_w[r.k], r.fev);
        check("pass", pass_w[r.k], r.pass);
        check("busy_after_done", busy_w[r.k], 0);
        if (r.busy >= 0) check("busy_cycles", busy_n, r.busy);
        if (r.k != 2) check("last_operands", {cin_w[r.k], b_w[r.k], a_w[r.k]}, 9'h1ff);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check("reset_state", all_out(k), 64'd0);
        rst = 1'b0;
        run('{0, 512, 0, 0, 512, 0, 1, 0}, -1);
        fmode = 1;
        run('{0, 512, 256, 1, -1, 1, 0, 0}, -1);
        fmode = 2;
        run('{0, 512, -1, -1, -1, 1, 0, 0}, -1);
        fmode = 0;
        run('{1, 512, 0, 0, 520, 0, 1, 1}, -1);
        run('{2, 100, 0, 0, 100, 0, 1, 0}, -1);
        run('{0, 512, 0, 0, 512, 0, 1, 0}, 200);
        run('{0, 512, 0, 0, 512, 0, 1, 0}, -1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
